// File: rtl/evb_pkg.sv
// Shared definitions for the EVB job scheduler: FSM encoding, job field widths, status codes.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package evb_pkg;

    // Engine job field widths
    localparam int A_W = 3;
    localparam int B_W = 5;
    localparam int X_W = 16;
    localparam int N_W = 5;

    // Status word reported when the watchdog gives up on the engine
    localparam logic [31:0] STATUS_TIMEOUT = 32'hDEAD_0001;
    // Status word held in rsp_status while reset is applied
    localparam logic [31:0] STATUS_RESET   = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    // Latched job fields handed to the engine
    typedef struct packed {
        logic [A_W-1:0] a;
        logic [B_W-1:0] b;
        logic [X_W-1:0] xb;
        logic [N_W-1:0] n;
    } job_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin select: first asserted req_valid at or after rr_ptr, circularly.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the caller decides whether the pick is consumed.
//
// Ports:
//   req_valid  per-requester request vector
//   rr_ptr     index with the highest priority this round
//   pick_vld   at least one request is pending
//   pick_id    index of the winning requester (valid with pick_vld)
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic               pick_vld,
    output logic [ID_W-1:0]    pick_id
);

    int idx;

    // Walk offsets from farthest to nearest so the nearest valid requester
    // after rr_ptr is the last (and therefore winning) assignment.
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = '0;
        idx      = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (req_valid[ID_W'(idx)]) begin
                pick_vld = 1'b1;
                pick_id  = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/evb_scheduler.sv
// Round-robin scheduler sharing one EVB engine between NUM_REQ requesters, one job at a time.
// Latency: accept at T (req_ready), eng_start at T+1, rsp_valid the cycle after eng_done.
// Backpressure: rsp_valid holds with stable rsp_* until rsp_ready; no new job is accepted meanwhile.
//
// Ports:
//   clk, rst                        clock (rising edge), asynchronous active-low reset
//   req_valid / req_ready           per-requester request, one-hot accept pulse (IDLE only)
//   req_A/b/xb/N/addr               packed per-requester job fields (requester i at slice i)
//   eng_start, eng_A/b/xb/N/addr    one-cycle start pulse and latched job fields to the engine
//   eng_done, eng_result/status     engine completion pulse and its outputs
//   rsp_valid/ready, rsp_id/result/status   response handshake back to the requesters
//   busy                            high whenever the FSM is not in IDLE
//
// Optional feature: define EVB_SCHED_TIMEOUT_EN to add a WAIT watchdog that forces a
// response with status STATUS_TIMEOUT after TIMEOUT cycles without eng_done.
module evb_scheduler
    import evb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 1024,
    localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*A_W-1:0]    req_A,
    input  logic [NUM_REQ*B_W-1:0]    req_b,
    input  logic [NUM_REQ*X_W-1:0]    req_xb,
    input  logic [NUM_REQ*N_W-1:0]    req_N,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,

    output logic                    eng_start,
    output logic [A_W-1:0]          eng_A,
    output logic [B_W-1:0]          eng_b,
    output logic [X_W-1:0]          eng_xb,
    output logic [N_W-1:0]          eng_N,
    output logic [ADDR_W-1:0]       eng_addr,
    input  logic                    eng_done,
    input  logic [31:0]             eng_result,
    input  logic [31:0]             eng_status,

    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [31:0]             rsp_result,
    output logic [31:0]             rsp_status,

    output logic                    busy
);

    state_t            state;
    logic [ID_W-1:0]   rr_ptr;
    job_t              job;
    logic [ADDR_W-1:0] job_addr;

    logic              pick_vld;
    logic [ID_W-1:0]   pick_id;
    logic              wait_expired;
    logic [ID_W-1:0]   next_ptr;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_picker (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .pick_vld  (pick_vld),
        .pick_id   (pick_id)
    );

    // The accept pulse must coincide with the IDLE cycle in which the pick is
    // sampled, so it is decoded from the state register rather than registered.
    // Gating with rst keeps it low while reset is held, even with requests pending.
    always_comb begin
        req_ready = '0;
        if (rst && (state == S_IDLE) && pick_vld) begin
            req_ready[pick_id] = 1'b1;
        end
    end

    // The next round starts just after the requester that was served.
    assign next_ptr = (rsp_id == ID_W'(NUM_REQ - 1)) ? '0 : rsp_id + 1'b1;

    assign eng_A    = job.a;
    assign eng_b    = job.b;
    assign eng_xb   = job.xb;
    assign eng_N    = job.n;
    assign eng_addr = job_addr;

`ifdef EVB_SCHED_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CNT_W-1:0] wait_cnt;

    assign wait_expired = (wait_cnt == CNT_W'(TIMEOUT - 1));
`else
    logic unused_timeout;

    assign wait_expired   = 1'b0;
    assign unused_timeout = (TIMEOUT != 0);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            rr_ptr     <= '0;
            eng_start  <= 1'b0;
            rsp_valid  <= 1'b0;
            busy       <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_status <= STATUS_RESET;
            job        <= '0;
            job_addr   <= '0;
`ifdef EVB_SCHED_TIMEOUT_EN
            wait_cnt   <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_vld) begin
                        state     <= S_START;
                        eng_start <= 1'b1;
                        busy      <= 1'b1;
                        rsp_id    <= pick_id;
                        job.a     <= req_A[pick_id*A_W +: A_W];
                        job.b     <= req_b[pick_id*B_W +: B_W];
                        job.xb    <= req_xb[pick_id*X_W +: X_W];
                        job.n     <= req_N[pick_id*N_W +: N_W];
                        job_addr  <= req_addr[pick_id*ADDR_W +: ADDR_W];
                    end
                end

                S_START: begin
                    state     <= S_WAIT;
                    eng_start <= 1'b0;
`ifdef EVB_SCHED_TIMEOUT_EN
                    wait_cnt  <= '0;
`endif
                end

                S_WAIT: begin
                    // A real completion beats a watchdog expiry in the same cycle.
                    if (eng_done) begin
                        state      <= S_RESP;
                        rsp_valid  <= 1'b1;
                        rsp_result <= eng_result;
                        rsp_status <= eng_status;
                    end else if (wait_expired) begin
                        state      <= S_RESP;
                        rsp_valid  <= 1'b1;
                        rsp_result <= '0;
                        rsp_status <= STATUS_TIMEOUT;
                    end
`ifdef EVB_SCHED_TIMEOUT_EN
                    else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end

                S_RESP: begin
                    if (rsp_ready) begin
                        state     <= S_IDLE;
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        rr_ptr    <= next_ptr;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_evb_scheduler.sv
// Directed bench for evb_scheduler: fairness, latency, backpressure, reset abandon, watchdog.
// Latency: n/a (testbench).
// Backpressure: bench drives rsp_ready low for a stall window before each handshake.
module tb_evb_scheduler;
    import evb_pkg::*;

    localparam int NR    = 4;
    localparam int AW    = 10;
    localparam int TO    = 16;
`ifdef EVB_SCHED_TIMEOUT_EN
    localparam int D_SINGLE = 10;
`else
    localparam int D_SINGLE = 20;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR-1:0]     req_ready;
    logic [NR*3-1:0]   req_A = '0;
    logic [NR*5-1:0]   req_b = '0;
    logic [NR*16-1:0]  req_xb = '0;
    logic [NR*5-1:0]   req_N = '0;
    logic [NR*AW-1:0]  req_addr = '0;
    logic              eng_start;
    logic [2:0]        eng_A;
    logic [4:0]        eng_b;
    logic [15:0]       eng_xb;
    logic [4:0]        eng_N;
    logic [AW-1:0]     eng_addr;
    logic              eng_done = 1'b0;
    logic [31:0]       eng_result = '0;
    logic [31:0]       eng_status = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [1:0]        rsp_id;
    logic [31:0]       rsp_result;
    logic [31:0]       rsp_status;
    logic              busy;

    evb_scheduler #(.NUM_REQ(NR), .ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_A(req_A), .req_b(req_b), .req_xb(req_xb), .req_N(req_N), .req_addr(req_addr),
        .eng_start(eng_start), .eng_A(eng_A), .eng_b(eng_b), .eng_xb(eng_xb),
        .eng_N(eng_N), .eng_addr(eng_addr),
        .eng_done(eng_done), .eng_result(eng_result), .eng_status(eng_status),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_status(rsp_status), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] res;
        logic [31:0] sts;
    } exp_t;

    exp_t sb[$];
    int   tests  = 0;
    int   fails  = 0;
    int   tb_ptr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int pick(input logic [NR-1:0] mask, input int ptr);
        for (int i = 0; i < NR; i++) begin
            if (mask[(ptr + i) % NR]) return (ptr + i) % NR;
        end
        return -1;
    endfunction

    // One complete job. d = cycles from WAIT entry to eng_done (0: never, expect watchdog).
    task automatic do_job(input logic [NR-1:0] mask, input int d, input logic [31:0] res,
                          input logic [31:0] sts, input int stall);
        int         w;
        int         n;
        exp_t       e;
        exp_t       got;
        logic [3:0] oh;
        w  = pick(mask, tb_ptr);
        oh = 4'b0001 << w;
        req_valid = mask;
        #1;
        chk("idle_busy", 32'(busy), 32'd0);
        chk("req_ready_grant", 32'(req_ready), 32'(oh));
        tick();                                   // accept edge
        req_valid = mask & ~oh;
        #1;
        chk("eng_start_pulse", 32'(eng_start), 32'd1);
        chk("req_ready_start", 32'(req_ready), 32'd0);
        chk("busy_start", 32'(busy), 32'd1);
        chk("eng_A", 32'(eng_A), 32'(w + 1));
        chk("eng_b", 32'(eng_b), 32'(w + 4));
        chk("eng_xb", 32'(eng_xb), 32'(w + 1));
        chk("eng_N", 32'(eng_N), 32'(w + 10));
        chk("eng_addr", 32'(eng_addr), 32'(256 + w));
        tick();                                   // enter WAIT
        chk("eng_start_once", 32'(eng_start), 32'd0);
        if (d == 0) begin
            repeat (TO - 1) tick();
            chk("wait_no_rsp", 32'(rsp_valid), 32'd0);
            tick();
            e = '{id: 2'(w), res: 32'd0, sts: STATUS_TIMEOUT};
        end else begin
            repeat (d - 1) tick();
            chk("wait_no_rsp", 32'(rsp_valid), 32'd0);
            chk("eng_xb_stable", 32'(eng_xb), 32'(w + 1));
            eng_done   = 1'b1;
            eng_result = res;
            eng_status = sts;
            tick();
            eng_done   = 1'b0;
            e = '{id: 2'(w), res: res, sts: sts};
        end
        sb.push_back(e);
        chk("rsp_valid_latency", 32'(rsp_valid), 32'd1);
        // Stall: stray eng_done pulses must be ignored, outputs must hold.
        for (int s = 0; s < stall; s++) begin
            eng_done   = 1'b1;
            eng_result = ~res;
            eng_status = ~sts;
            tick();
            eng_done   = 1'b0;
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_result", rsp_result, e.res);
            chk("bp_rsp_status", rsp_status, e.sts);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        n = 0;
        while (!rsp_valid && n < 50) begin
            tick();
            n++;
        end
        if (!rsp_valid) chk("rsp_wait_budget", 32'(rsp_valid), 32'd1);
        if (sb.size() == 0) begin
            chk("sb_nonempty", 32'd0, 32'd1);
        end else begin
            got = sb.pop_front();
            chk("rsp_id", 32'(rsp_id), 32'(got.id));
            chk("rsp_result", rsp_result, got.res);
            chk("rsp_status", rsp_status, got.sts);
        end
        tick();                                   // handshake edge
        rsp_ready = 1'b0;
        req_valid = '0;
        #1;
        chk("rsp_valid_drop", 32'(rsp_valid), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
        tb_ptr = (w + 1) % NR;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_eng_start"}, 32'(eng_start), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_rsp_id"}, 32'(rsp_id), 32'd0);
        chk({tag, "_rsp_result"}, rsp_result, 32'd0);
        chk({tag, "_rsp_status"}, rsp_status, STATUS_RESET);
        chk({tag, "_eng_fields"}, 32'({eng_A, eng_b, eng_N, eng_addr}), 32'd0);
        chk({tag, "_eng_xb"}, 32'(eng_xb), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < NR; i++) begin
            req_A[i*3 +: 3]     = 3'(i + 1);
            req_b[i*5 +: 5]     = 5'(i + 4);
            req_xb[i*16 +: 16]  = 16'(i + 1);
            req_N[i*5 +: 5]     = 5'(i + 10);
            req_addr[i*AW +: AW] = AW'(256 + i);
        end

        // Reset state with every requester asking
        req_valid = 4'b1111;
        tick();
        tick();
        chk_reset_vals("rst0");
        req_valid = '0;
        rst = 1'b1;
        tick();

        // Fairness: five back-to-back jobs with everyone requesting -> 0,1,2,3,0
        for (int k = 0; k < 5; k++) begin
            do_job(4'b1111, 3, 32'h100 + 32'(k), 32'(k), 0);
        end

        // Single request from requester 2, xb=3, result 0x1C
        do_job(4'b0100, D_SINGLE, 32'h0000_001C, 32'h0, 0);

        // Backpressure for 5 cycles, winner 3 then pointer wraps to 0
        do_job(4'b1001, 4, 32'hCAFE_0003, 32'h0000_0033, 5);
        do_job(4'b0110, 2, 32'h1234_5678, 32'h0000_0001, 1);

        // Reset in WAIT abandons the job
        req_valid = 4'b0100;
        #1;
        chk("pre_rst_grant", 32'(req_ready), 32'b0100);
        tick();
        req_valid = 4'b1010;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk_reset_vals("rst_wait");
        tick();
        req_valid = '0;
        tick();
        rst = 1'b1;
        tb_ptr = 0;
        eng_done   = 1'b1;
        eng_result = 32'hBAD0_BAD0;
        tick();
        eng_done   = 1'b0;
        repeat (3) tick();
        chk("no_rsp_after_rst", 32'(rsp_valid), 32'd0);
        chk("sb_empty_after_rst", 32'(sb.size()), 32'd0);
        do_job(4'b1111, 2, 32'h0000_00A5, 32'h0, 0);

`ifdef EVB_SCHED_TIMEOUT_EN
        do_job(4'b0001, 0, 32'h0, 32'h0, 0);
        do_job(4'b0010, TO, 32'h0000_0077, 32'h0000_0055, 0);
`else
        do_job(4'b0001, 40, 32'h0000_0040, 32'h0000_0002, 0);
`endif

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "bench watchdog expired");
    end

endmodule

// File: doc/evb_scheduler.md
EVB_SCHEDULER -- requirements
Module: evb_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one EVB engine.
REQ-002 Parameter ADDR_W, default 10, width of the data-buffer read address.
REQ-003 Parameter TIMEOUT, default 1024, watchdog limit in cycles spent in WAIT.
REQ-004 clk  in  1  clock; rising edge.
REQ-005 rst  in  1  reset; asynchronous, active-low.
REQ-006 req_valid  in  NUM_REQ  per-requester job request.
REQ-007 req_ready  out  NUM_REQ  one-hot job-accept pulse.
REQ-008 req_A/req_b/req_xb/req_N/req_addr  in  NUM_REQ x 3/5/16/5/ADDR_W  packed per-requester job fields.
REQ-009 eng_start  out  1  one-cycle start pulse to the EVB engine.
REQ-010 eng_A/eng_b/eng_xb/eng_N/eng_addr  out  3/5/16/5/ADDR_W  latched job fields to the engine.
REQ-011 eng_done  in  1  engine completion pulse.
REQ-012 eng_result/eng_status  in  32/32  engine outputs, valid with eng_done.
REQ-013 rsp_valid  out  1; rsp_ready  in  1  response handshake.
REQ-014 rsp_id  out  clog2(NUM_REQ)  granted requester index.
REQ-015 rsp_result/rsp_status  out  32/32  job result and status.
REQ-016 busy  out  1  high in every state except IDLE.

Function
REQ-017 FSM states: IDLE, START, WAIT, RESP.
REQ-018 IDLE: if any req_valid is high, the winner is the first set bit at or after rr_ptr, circularly; req_ready[winner]=1 for that cycle; fields and id are latched; next state is START.
REQ-019 IDLE with no req_valid: all outputs hold and the state stays IDLE.
REQ-020 START: eng_start=1 for exactly one cycle; next state is WAIT.
REQ-021 WAIT: on eng_done, latch eng_result/eng_status into rsp_result/rsp_status; next state is RESP.
REQ-022 eng_done outside WAIT is ignored.
REQ-023 RESP: rsp_valid is held high, with rsp_* stable, until rsp_ready=1; then rr_ptr=(winner+1) mod NUM_REQ and next state is IDLE.
REQ-024 Latency: accept at cycle T, eng_start at T+1, rsp_valid at the cycle after eng_done.
REQ-025 req_ready is never asserted outside IDLE; requesters keep req_valid high until accepted.
REQ-026 eng_* fields stay stable from START until leaving WAIT.
REQ-027 rr_ptr wraps from NUM_REQ-1 to 0.

Reset
REQ-028 With rst low: state=IDLE, rr_ptr=0, req_ready=0, eng_start=0, rsp_valid=0, busy=0, rsp_id=0, rsp_result=0, rsp_status=32'hFFFF_FFFF, eng_* fields=0.
REQ-029 Reset mid-job abandons the job; no response is produced.

Configuration
REQ-030 Macro EVB_SCHED_TIMEOUT_EN.
- Defined: a cycle counter runs in WAIT. When it reaches TIMEOUT-1 without eng_done, the block enters RESP with rsp_result=0 and rsp_status=32'hDEAD_0001.
- eng_done in the same cycle as the timeout wins.
- The counter clears on entering WAIT.
REQ-031 Macro undefined: no counter exists and WAIT is left only on eng_done.

Structure
REQ-032 Shared package evb_pkg holds: state encoding, STATUS_TIMEOUT=32'hDEAD_0001, STATUS_RESET=32'hFFFF_FFFF, field widths (A=3, b=5, x=16, N=5).
REQ-033 One sub-module, rr_picker: combinational round-robin winner select from req_valid and rr_ptr.

Verification
REQ-034 Single request: req_valid=4'b0100 with xb=16'h0003, eng_done 20 cycles later carrying result 32'h0000_001C -> req_ready=4'b0100 at T, eng_start at T+1, rsp_id=2, rsp_result=32'h1C.
REQ-035 Fairness: all four req_valid held high for four jobs -> grant order 0,1,2,3; then rr_ptr=0.
REQ-036 Backpressure: rsp_ready held low for 5 cycles -> rsp_valid and rsp_* stable; no new req_ready pulse.
REQ-037 Timeout (macro defined, TIMEOUT=16): no eng_done -> RESP after 16 WAIT cycles with status 32'hDEAD_0001. eng_done arriving at the same cycle as the timeout -> engine status is reported.
REQ-038 Reset asserted during WAIT -> all outputs take their REQ-028 values asynchronously; a fresh request after reset is granted starting from rr_ptr=0.
